// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction-fetch stage: PC, instruction-ROM port initiator, decode-stage register
//
// Owns the program counter and drives the instruction ROM. The word the ROM
// returns combinationally is captured with {pc, inst, valid} into registers
// presented to decode. Branch redirects from execute take priority over stall.
//
// Build option: define INST_FETCH_QUEUE_EN to insert a 2-entry in-order
// {pc, inst} queue between the ROM and the id_* registers, so fetching
// continues for up to two words while decode is stalled.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active high
//   stall          decode cannot accept this cycle
//   branch_flag    redirect request from execute
//   branch_target  redirect byte address (low two bits ignored)
//   rom_ce         ROM chip enable
//   rom_addr       ROM byte address (word aligned)
//   rom_inst       ROM data, combinational from rom_addr
//   id_pc          PC of the presented instruction
//   id_inst        presented instruction
//   id_valid       id_pc/id_inst hold a live instruction

module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    logic [31:0] pc;
    logic        ce_q;

    assign rom_ce   = ce_q;
    assign rom_addr = pc;

`ifndef INST_FETCH_QUEUE_EN

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= 32'd0;
            ce_q     <= CHIP_DISABLE;
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (ce_q == CHIP_DISABLE) begin
            // One idle edge after reset to enable the ROM; pc stays at 0.
            ce_q <= CHIP_ENABLE;
        end else if (branch_flag) begin
            // The word currently on rom_inst is wrong-path: drop it.
            pc       <= {branch_target[31:2], 2'b00};
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_pc    <= pc;
            id_inst  <= rom_inst;
            id_valid <= 1'b1;
            pc       <= pc + 32'd4;
        end
    end

`else

    logic [31:0] q_pc   [2];
    logic [31:0] q_inst [2];
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        advance;
    logic        wr_idx;

    always_comb begin
        pop     = !stall && (count != 2'd0);
        // With an empty queue and no stall the ROM word bypasses straight to
        // id_*; otherwise every fetched word goes through the queue.
        push    = stall ? (count != 2'd2) : (count != 2'd0);
        advance = !stall || (count != 2'd2);
        // Slot for the new word after any pop has shifted the head out.
        wr_idx  = pop ? (count == 2'd2) : (count == 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= 32'd0;
            ce_q      <= CHIP_DISABLE;
            id_pc     <= 32'd0;
            id_inst   <= 32'd0;
            id_valid  <= 1'b0;
            count     <= 2'd0;
            q_pc[0]   <= 32'd0;
            q_pc[1]   <= 32'd0;
            q_inst[0] <= 32'd0;
            q_inst[1] <= 32'd0;
        end else if (ce_q == CHIP_DISABLE) begin
            ce_q <= CHIP_ENABLE;
        end else if (branch_flag) begin
            pc       <= {branch_target[31:2], 2'b00};
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (advance) begin
                pc <= pc + 32'd4;
            end
            if (!stall) begin
                id_valid <= 1'b1;
                if (count != 2'd0) begin
                    id_pc   <= q_pc[0];
                    id_inst <= q_inst[0];
                end else begin
                    id_pc   <= pc;
                    id_inst <= rom_inst;
                end
            end
            if (pop) begin
                q_pc[0]   <= q_pc[1];
                q_inst[0] <= q_inst[1];
            end
            // Placed after the shift so a write to slot 0 wins over it.
            if (push) begin
                q_pc[wr_idx]   <= pc;
                q_inst[wr_idx] <= rom_inst;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a queue-based reference model

module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int checks;
    int errors;

    // ROM content: address XOR key (key 0 gives word == address).
    logic [31:0] key;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_valid;
    logic [63:0] mq[$];

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid)
    );

    assign rom_inst = rom_addr ^ key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rom_ce"},   {31'd0, rom_ce},   {31'd0, m_ce});
        chk({tag, ".rom_addr"}, rom_addr,          m_pc);
        chk({tag, ".id_pc"},    id_pc,             m_id_pc);
        chk({tag, ".id_inst"},  id_inst,           m_id_inst);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    endtask

    task automatic model_reset();
        m_pc      = 32'd0;
        m_ce      = 1'b0;
        m_id_pc   = 32'd0;
        m_id_inst = 32'd0;
        m_valid   = 1'b0;
        mq.delete();
    endtask

    // Next state from the rules: branch flushes everything, otherwise the
    // stream of fetched words reaches decode in order, one per non-stalled cycle.
    task automatic model_step(input logic s, input logic b, input logic [31:0] t);
        logic [63:0] cur;
        logic [63:0] head;
        cur = {m_pc, m_pc ^ key};
        if (!m_ce) begin
            m_ce = 1'b1;
        end else if (b) begin
            m_pc      = {t[31:2], 2'b00};
            m_valid   = 1'b0;
            m_id_pc   = 32'd0;
            m_id_inst = 32'd0;
            mq.delete();
        end else begin
`ifdef INST_FETCH_QUEUE_EN
            if (!s) begin
                if (mq.size() > 0) begin
                    head = mq.pop_front();
                    mq.push_back(cur);
                end else begin
                    head = cur;
                end
                m_id_pc   = head[63:32];
                m_id_inst = head[31:0];
                m_valid   = 1'b1;
                m_pc      = m_pc + 32'd4;
            end else if (mq.size() < 2) begin
                mq.push_back(cur);
                m_pc = m_pc + 32'd4;
            end
`else
            head = cur;
            if (!s) begin
                m_id_pc   = head[63:32];
                m_id_inst = head[31:0];
                m_valid   = 1'b1;
                m_pc      = m_pc + 32'd4;
            end
`endif
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t, input string tag);
        stall         = s;
        branch_flag   = b;
        branch_target = t;
        model_step(s, b, t);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all({tag, ".imm"});
        chk({tag, ".imm.addr0"},  rom_addr, 32'd0);
        chk({tag, ".imm.valid0"}, {31'd0, id_valid}, 32'd0);
        @(posedge clk);
        #1;
        compare_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        key           = 32'd0;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'd0;
        model_reset();

        do_reset("reset");

        // Start-up: one idle edge enables the ROM, then sequential fetch.
        step(1'b0, 1'b0, 32'd0, "boot1");
        chk("boot1.ce_up", {31'd0, rom_ce}, 32'd1);
        chk("boot1.novalid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, "boot2");
        chk("boot2.valid", {31'd0, id_valid}, 32'd1);
        chk("boot2.pc0", id_pc, 32'h0);
        chk("boot2.addr4", rom_addr, 32'h4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, "run");
        chk("run.id_pc_c", id_pc, 32'hC);
        chk("run.id_inst_c", id_inst, 32'hC);
        chk("run.addr10", rom_addr, 32'h10);

        // Stall three cycles at pc=0x10, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "stall");
        chk("stall.id_pc_frozen", id_pc, 32'hC);
`ifdef INST_FETCH_QUEUE_EN
        chk("stall.addr", rom_addr, 32'h18);
`else
        chk("stall.addr", rom_addr, 32'h10);
`endif
        step(1'b0, 1'b0, 32'd0, "release");
        chk("release.next", id_pc, 32'h10);

        // Branch during stall: redirect wins, low address bits dropped.
        step(1'b1, 1'b1, 32'h103, "br_stall");
        chk("br_stall.addr", rom_addr, 32'h100);
        chk("br_stall.flush", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, "br_target");
        chk("br_target.pc", id_pc, 32'h100);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_br");
        step(1'b0, 1'b0, 32'd0, "wrap1");
        chk("wrap1.pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap1.addr", rom_addr, 32'h0);
        step(1'b0, 1'b0, 32'd0, "wrap2");
        chk("wrap2.pc", id_pc, 32'h0);

        // Randomised traffic against the reference model.
        key = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic s;
            logic b;
            s = ($urandom_range(0, 9) < 4);
            b = ($urandom_range(0, 99) < 8);
            step(s, b, $urandom, "rand");
        end

        // Reset while stalled with the queue full, then restart from 0.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, "prefill");
        do_reset("midrst");
        step(1'b0, 1'b0, 32'd0, "restart1");
        step(1'b0, 1'b0, 32'd0, "restart2");
        chk("restart2.pc0", id_pc, 32'h0);
        chk("restart2.valid", {31'd0, id_valid}, 32'd1);

        // Stall one cycle, then branch on the release cycle.
        step(1'b1, 1'b0, 32'd0, "qb_stall");
        step(1'b0, 1'b1, 32'h2000, "qb_branch");
        chk("qb_branch.flush", {31'd0, id_valid}, 32'd0);
        chk("qb_branch.addr", rom_addr, 32'h2000);
        step(1'b0, 1'b0, 32'd0, "qb_target");
        chk("qb_target.pc", id_pc, 32'h2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage and initiator of the instruction-ROM port. Owns the program counter, drives the ROM chip-enable and byte address, captures the 32-bit word the ROM returns in the same cycle, and presents a registered {pc, inst, valid} triple to the decode stage. Honours pipeline stall from the controller and branch/jump redirects from execute.

## Interface
- No parameters; widths are fixed at 32 bits (`InstAddrBus`, `InstBus`).

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active high
- stall  input  1  downstream (decode) cannot accept this cycle
- branch_flag  input  1  redirect request from execute
- branch_target  input  32  redirect byte address
- rom_ce  output  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- rom_addr  output  32  ROM byte address (word-aligned)
- rom_inst  input  32  ROM data, combinational from rom_addr
- id_pc  output  32  PC of the presented instruction
- id_inst  output  32  presented instruction
- id_valid  output  1  id_pc/id_inst hold a live instruction

## Operation
- Registers: pc, ce_q, id_pc, id_inst, id_valid (+ queue when enabled).
- rom_ce = ce_q; rom_addr = pc. While rom_ce is disabled, pc stays 0 and no capture occurs.
- Per edge, priority order: reset > branch_flag > stall > normal.
- branch_flag=1: pc <= {branch_target[31:2],2'b00}; id_valid <= 0 (wrong-path word in flight discarded); id_pc/id_inst <= 0. Applies even when stall=1.
- stall=1 (no branch): pc, id_pc, id_inst, id_valid hold.
- Normal: id_pc <= pc; id_inst <= rom_inst; id_valid <= 1; pc <= pc + 4.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000. Bits [1:0] of pc are always 0.
- Fetched words are consumed in order; no word is duplicated or dropped except on branch flush.

## Timing
- Reset (async, immediate): pc=0, ce_q=0, rom_ce=`ChipDisable`, rom_addr=0, id_pc=0, id_inst=0, id_valid=0.
- First edge after rst falls: ce_q <= 1; pc stays 0. Second edge: word at 0x0 captured, id_valid=1, pc=4.
- Fetch-to-decode latency: 1 cycle (word at rom_addr in cycle t appears on id_* after edge t).
- Redirect: branch_flag high in cycle t -> rom_addr=target in cycle t+1 -> target instruction on id_* in cycle t+2; id_valid=0 in cycle t+1.
- Stall released in cycle t: advance resumes on edge t with no lost or repeated word.
- rst asserted mid-operation: all state returns to reset values in the same cycle, regardless of stall/branch.

## Configuration
- Macro `INST_FETCH_QUEUE_EN`.
- Without it: behaviour exactly as above; stall freezes the PC.
- With it: a 2-entry in-order queue of {pc, inst} sits between ROM and id_* registers. Fetch (push, pc += 4) continues during stall while queue count < 2 (or a pop frees a slot the same cycle); at count 2 with stall, pc holds. When stall=0: id_* <= queue head if count > 0, else bypass the current ROM word (same 1-cycle latency as without the macro); id_valid <= 1 if a word was available. Simultaneous push and pop keeps count. branch_flag clears the queue (count <= 0) and id_valid in the same edge. Reset: count=0.

## Test plan
- Reset then free-run 6 cycles, ROM word = address: rom_ce rises after first edge; id_pc sequence 0x0,0x4,0x8,0xC with id_inst matching, id_valid=1 from cycle 2.
- stall=1 for 3 cycles at pc=0x10: id_pc/id_inst frozen at 0x0C, rom_addr stays 0x10 (queue mode: rom_addr advances to 0x18 then holds); after release, 0x10 presented next, no duplicate.
- branch_flag with target 0x103 while stall=1: next cycle rom_addr=0x100, id_valid=0; following cycle id_pc=0x100.
- pc forced via branch to 0xFFFF_FFFC: next fetched id_pc after 0xFFFF_FFFC is 0x0.
- Assert rst while stall=1 and queue full: all outputs reset immediately, count=0, fetch restarts at 0x0.
- Queue mode: stall 1 cycle then branch in same cycle as release: queued words discarded, first valid id_pc is the target.
